// File: rtl/imem_resp.sv
// Instruction-memory responder: accepts fetch addresses, reads a word-addressed store and
// returns (instruction, echoed address, fault) in order after LATENCY cycles, with flush.
module imem_resp #(
  parameter int  DEPTH_WORDS = 1024,
  parameter int  LATENCY     = 2,
  parameter int  FIFO_DEPTH  = 4,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_inst,
  output logic [31:0]   resp_addr,
  output logic          resp_fault,
  input  logic          flush,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data
);

  // Handshakes: a transfer happens at a rising edge where valid && ready. req_ready never
  // looks at req_valid; resp_* stay stable while resp_valid && !resp_ready.

  localparam int          PS         = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam int          PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef struct packed {
    logic        fault;
    logic [31:0] addr;
    logic [31:0] inst;
  } entry_t;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [PS-1:0] pv_q;
  entry_t        pe_q [PS];
  entry_t        fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_idx;
  logic [CW-1:0] cnt_q, cnt_d, out_q, out_d;

  logic          accept, pop, req_fault, push_v;
  logic [AW-1:0] word_idx;
  entry_t        new_e, push_e, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_ready  = flush || (out_q < CW'(FIFO_DEPTH));
  assign accept     = req_valid && req_ready;
  assign resp_valid = (cnt_q != '0) && !flush;
  assign pop        = resp_valid && resp_ready;

  assign word_idx    = req_addr[AW+1:2];
  assign req_fault   = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= ADDR_LIMIT);
  assign new_e.fault = req_fault;
  assign new_e.addr  = req_addr;
  assign new_e.inst  = req_fault ? NOP_INST : mem_q[word_idx];

  assign head       = fifo_q[rd_ptr_q];
  assign resp_inst  = head.inst;
  assign resp_addr  = head.addr;
  assign resp_fault = head.fault;

  // With LATENCY 1 the registered store read lands straight in the FIFO, so the entry
  // pushed during a flush is the redirect target and survives; otherwise it is stale.
  generate
    if (LATENCY == 1) begin : g_direct
      assign push_v = accept;
      assign push_e = new_e;
    end else begin : g_pipe
      assign push_v = pv_q[PS-1] && !flush;
      assign push_e = pe_q[PS-1];
    end
  endgenerate

  // Store: not reset, never blocked; the nonblocking write gives read-before-write.
  always_ff @(posedge clk) begin
    if (load_we) mem_q[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
    end else begin
      pv_q[0] <= accept;
      for (int i = 1; i < PS; i++) pv_q[i] <= flush ? 1'b0 : pv_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pe_q[0] <= new_e;
    for (int i = 1; i < PS; i++) pe_q[i] <= pe_q[i-1];
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    wr_idx   = wr_ptr_q;
    cnt_d    = cnt_q;
    out_d    = out_q + CW'(accept) - CW'(pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_idx   = '0;
      wr_ptr_d = push_v ? ptr_inc('0) : '0;
      cnt_d    = CW'(push_v);
      out_d    = CW'(accept);
    end else begin
      if (pop)    rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_v) wr_ptr_d = ptr_inc(wr_ptr_q);
      cnt_d = cnt_q + CW'(push_v) - CW'(pop);
    end
  end

  // Storage is cleared on reset so the response outputs start at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (push_v) begin
      fifo_q[wr_idx] <= push_e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

endmodule

// File: tb/tb_imem_resp.sv
// Bench for imem_resp: directed scenario tasks with inline checks plus a cycle scoreboard
// that predicts every response from a queue-based model of the fetch responder.
module tb_imem_resp;

  localparam int DEPTH_WORDS = 1024;
  localparam int LATENCY     = 2;
  localparam int FIFO_DEPTH  = 4;
  localparam int AW          = $clog2(DEPTH_WORDS);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, resp_valid, resp_ready, resp_fault;
  logic [31:0]   req_addr, resp_inst, resp_addr;
  logic          flush, load_we;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;

  int n_tests = 0;
  int n_fail  = 0;
  bit sb_en   = 1'b0;
  int cyc     = 0;

  // Reference model: store image, expected responses {fault, addr, inst} and due cycles.
  logic [31:0] mem_m [DEPTH_WORDS];
  logic [64:0] exp_q [$];
  int          due_q [$];

  imem_resp #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst),
    .resp_addr(resp_addr), .resp_fault(resp_fault),
    .flush(flush), .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;

  // Scoreboard: inputs settle at the falling edge; check at +2, then apply the coming edge.
  always begin : sb
    logic        ev, er, f;
    logic [64:0] ent;
    int          idx;
    @(negedge clk);
    #2;
    if (sb_en) begin
      ev = !flush && (exp_q.size() > 0) && (due_q[0] <= cyc);
      er = flush || (exp_q.size() < FIFO_DEPTH);
      n_tests++;
      if (resp_valid !== ev) begin
        n_fail++;
        $display("FAIL sb_resp_valid cyc=%0d got=%b exp=%b", cyc, resp_valid, ev);
      end
      n_tests++;
      if (req_ready !== er) begin
        n_fail++;
        $display("FAIL sb_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, er);
      end
      if (ev) begin
        n_tests++;
        if ({resp_fault, resp_addr, resp_inst} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL sb_resp_data cyc=%0d got=%h exp=%h", cyc,
                   {resp_fault, resp_addr, resp_inst}, exp_q[0]);
        end
      end
      if (rst) begin
        exp_q.delete();
        due_q.delete();
      end else begin
        if (flush) begin
          exp_q.delete();
          due_q.delete();
        end else if (ev && resp_ready) begin
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
        if (req_valid && er) begin
          f   = (req_addr % 4 != 0) || (longint'(req_addr) >= longint'(DEPTH_WORDS) * 4);
          idx = int'((req_addr / 4) % DEPTH_WORDS);
          ent = {f, req_addr, f ? 32'h0000_0013 : mem_m[idx]};
          exp_q.push_back(ent);
          due_q.push_back(cyc + LATENCY);
        end
      end
    end
    if (load_we) mem_m[load_addr] = load_data;
    cyc++;
  end

  function automatic logic [31:0] rand_addr();
    int          kind;
    logic [31:0] a;
    kind = $urandom_range(0, 9);
    if (kind == 0)      a = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
    else if (kind == 1) a = $urandom() | 32'h0000_1000;
    else                a = 32'($urandom_range(0, 1023)) << 2;
    return a;
  endfunction

  task automatic idle_inputs();
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0; flush = 1'b0;
    load_we = 1'b0; load_addr = '0; load_data = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      idle_inputs();
      resp_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    n_tests++; if (resp_inst !== 32'h0) begin n_fail++; $display("FAIL reset_resp_inst got=%h exp=0", resp_inst); end
    n_tests++; if (resp_addr !== 32'h0) begin n_fail++; $display("FAIL reset_resp_addr got=%h exp=0", resp_addr); end
    n_tests++; if (resp_fault !== 1'b0) begin n_fail++; $display("FAIL reset_resp_fault got=%b exp=0", resp_fault); end
    sb_en = 1'b1;
  endtask

  task automatic preload_store();
    for (int i = 0; i < DEPTH_WORDS; i++) begin
      @(negedge clk);
      load_we = 1'b1; load_addr = AW'(i); load_data = $urandom();
    end
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk); load_we = 1'b1; load_addr = AW'(0); load_data = 32'h0050_0093;
    @(negedge clk); load_we = 1'b1; load_addr = AW'(1); load_data = 32'h00A0_0113;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      load_we = 1'b0; resp_ready = 1'b1;
      req_valid = (k < 2); req_addr = 32'(k) * 4;
      #1;
      if (k == 2) begin
        n_tests++;
        if (resp_valid !== 1'b1 || resp_inst !== 32'h0050_0093 || resp_addr !== 32'h0 || resp_fault !== 1'b0) begin
          n_fail++; $display("FAIL basic_first got v=%b %h @%h f=%b exp v=1 00500093 @0 f=0", resp_valid, resp_inst, resp_addr, resp_fault);
        end
      end
      if (k == 3) begin
        n_tests++;
        if (resp_valid !== 1'b1 || resp_inst !== 32'h00A0_0113 || resp_addr !== 32'h4 || resp_fault !== 1'b0) begin
          n_fail++; $display("FAIL basic_second got v=%b %h @%h f=%b exp v=1 00a00113 @4 f=0", resp_valid, resp_inst, resp_addr, resp_fault);
        end
      end
      if (k == 4) begin
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty got=%b exp=0", resp_valid); end
      end
    end
    drain();
  endtask

  task automatic test_fault();
    logic [31:0] addrs [3];
    addrs[0] = 32'h6; addrs[1] = 32'h1000; addrs[2] = 32'hFFC;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      resp_ready = 1'b1; req_valid = (k < 3); req_addr = (k < 3) ? addrs[k] : 32'h0;
      #1;
      if (k == 2 || k == 3) begin
        n_tests++;
        if (resp_valid !== 1'b1 || resp_inst !== 32'h13 || resp_addr !== addrs[k-2] || resp_fault !== 1'b1) begin
          n_fail++; $display("FAIL fault_resp got v=%b %h @%h f=%b exp v=1 00000013 @%h f=1", resp_valid, resp_inst, resp_addr, resp_fault, addrs[k-2]);
        end
      end
      if (k == 4) begin
        n_tests++;
        if (resp_valid !== 1'b1 || resp_addr !== 32'hFFC || resp_fault !== 1'b0) begin
          n_fail++; $display("FAIL fault_last_word got v=%b @%h f=%b exp v=1 @ffc f=0", resp_valid, resp_addr, resp_fault);
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int hs  = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'(k) * 4;
      #1;
      if (req_ready) acc++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_tests++; if (acc !== 4) begin n_fail++; $display("FAIL bp_accept_count got=%0d exp=4", acc); end
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got=%b exp=0", req_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if (resp_valid !== 1'b1 || resp_inst !== 32'h0050_0093 || resp_addr !== 32'h0) begin
        n_fail++; $display("FAIL bp_hold got v=%b %h @%h exp v=1 00500093 @0", resp_valid, resp_inst, resp_addr);
      end
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      resp_ready = 1'b1;
      #1;
      if (k == 0) begin
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_same_cycle got=%b exp=0", req_ready); end
      end
      if (k == 1) begin
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_next_cycle got=%b exp=1", req_ready); end
      end
      if (resp_valid) begin
        n_tests++;
        if (resp_addr !== 32'(hs) * 4) begin n_fail++; $display("FAIL bp_order got=%h exp=%h", resp_addr, 32'(hs) * 4); end
        hs++;
      end
    end
    n_tests++; if (hs !== 4) begin n_fail++; $display("FAIL bp_resp_count got=%0d exp=4", hs); end
    drain();
  endtask

  task automatic test_flush();
    int hs = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h8 + 32'(k) * 4;
    end
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h40;
    #1;
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_resp_valid got=%b exp=0", resp_valid); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_req_ready got=%b exp=1", req_ready); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
      #1;
      if (resp_valid) begin
        hs++;
        n_tests++; if (resp_addr !== 32'h40) begin n_fail++; $display("FAIL flush_target_addr got=%h exp=40", resp_addr); end
        n_tests++; if (k !== 2) begin n_fail++; $display("FAIL flush_target_cycle got=%0d exp=2", k); end
      end
    end
    n_tests++; if (hs !== 1) begin n_fail++; $display("FAIL flush_resp_count got=%0d exp=1", hs); end
    drain();
  endtask

  task automatic test_rbw();
    @(negedge clk);
    load_we = 1'b1; load_addr = AW'(5); load_data = 32'h1111_1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      resp_ready = 1'b1;
      load_we = (k == 0); load_data = 32'hDEAD_BEEF;
      req_valid = (k < 2); req_addr = 32'h14;
      #1;
      if (k == 2) begin
        n_tests++; if (resp_valid !== 1'b1 || resp_inst !== 32'h1111_1111) begin n_fail++; $display("FAIL rbw_old_word got v=%b %h exp v=1 11111111", resp_valid, resp_inst); end
      end
      if (k == 3) begin
        n_tests++; if (resp_valid !== 1'b1 || resp_inst !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rbw_new_word got v=%b %h exp v=1 deadbeef", resp_valid, resp_inst); end
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int hs = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      resp_ready = 1'b1; req_valid = (k < 10); req_addr = 32'($urandom_range(0, 1023)) << 2;
      #1;
      if (k < 10) begin
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_req_ready k=%0d got=%b exp=1", k, req_ready); end
      end
      if (resp_valid) hs++;
    end
    n_tests++; if (hs !== 10) begin n_fail++; $display("FAIL b2b_resp_count got=%0d exp=10", hs); end
    drain();
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    @(negedge clk); resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    @(negedge clk); req_addr = 32'h4;
    @(negedge clk); req_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_resp_valid got=%b exp=0", resp_valid); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_ready got=%b exp=1", req_ready); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      resp_ready = 1'b1;
      #1;
      if (resp_valid) seen++;
    end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_resp got=%0d exp=0", seen); end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      req_valid  = 1'($urandom_range(0, 1));
      req_addr   = rand_addr();
      resp_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 24) == 0);
      load_we    = ($urandom_range(0, 3) == 0);
      load_addr  = ($urandom_range(0, 3) == 0) ? AW'(req_addr / 4) : AW'($urandom_range(0, DEPTH_WORDS - 1));
      load_data  = $urandom();
    end
    drain();
    #1;
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rand_drained_valid got=%b exp=0", resp_valid); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rand_drained_ready got=%b exp=1", req_ready); end
  endtask

  initial begin
    test_reset();
    preload_store();
    test_basic();
    test_fault();
    test_backpressure();
    test_flush();
    test_rbw();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_resp.md
# imem_resp

Instruction-memory responder for the RISC-V core's fetch path: the consuming end of the PC/fetch-address stream. It accepts fetch addresses over a valid/ready request channel, reads a word-addressed instruction store, and returns the instruction, the echoed address and a fault flag over a valid/ready response channel after a fixed latency. Responses return in order. A flush input discards all in-flight fetches when the PC is redirected by a jal, jalr or taken branch. A load port fills the store before or during operation.

## Interface
- DEPTH_WORDS, 1024: instruction store size in 32-bit words; power of two, at least 2.
- LATENCY, 2: cycles from request acceptance to earliest response; range 1..4.
- FIFO_DEPTH, 4: maximum outstanding fetches, counting in-flight and buffered; must be at least 1.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock; synchronous, active-high.
- req_valid  input  1  fetch address valid.
- req_ready  output  1  responder can accept a fetch this cycle.
- req_addr  input  32  byte address of the instruction.
- resp_valid  output  1  response word valid.
- resp_ready  input  1  consumer accepts the response.
- resp_inst  output  32  instruction word; 32'h00000013 (NOP) on fault.
- resp_addr  output  32  req_addr echoed for this response.
- resp_fault  output  1  misaligned or out-of-range fetch.
- flush  input  1  discard every outstanding fetch.
- load_we  input  1  write one word into the store.
- load_addr  input  log2(DEPTH_WORDS)  word index for the load write.
- load_data  input  32  word to write.

## Operation
- Accept: a fetch is accepted when req_valid && req_ready at a rising edge.
- Word index: req_addr[log2(DEPTH_WORDS)+1:2].
- Fault: set when req_addr[1:0] != 0, or when req_addr >= DEPTH_WORDS*4 (unsigned 32-bit compare).
  - A faulting fetch still occupies a slot.
  - It returns resp_inst = 32'h00000013 and resp_fault = 1; no store read is used.
- Store read: synchronous, in the acceptance cycle.
  - A load_we to the same word in the same cycle is written at that edge.
  - The read returns the old contents (read-before-write).
- Pipeline and buffer:
  - LATENCY-stage valid/data pipeline feeding an in-order FIFO of FIFO_DEPTH entries.
  - The FIFO head drives the resp_* outputs.
- Outstanding counter, 0..FIFO_DEPTH:
  - +1 on accept; -1 on response handshake (resp_valid && resp_ready); unchanged when both occur.
  - req_ready = flush || (outstanding < FIFO_DEPTH). It never depends on req_valid.
- Flush, applied at the edge:
  - Clears all pipeline valid bits and the FIFO; outstanding becomes 0.
  - resp_valid is forced 0 during the flush cycle.
  - A request accepted in the flush cycle is kept: it is the redirect target, so outstanding becomes 1.
- Response hold: while resp_valid && !resp_ready, resp_inst, resp_addr and resp_fault are held stable.
- Pipeline never stalls: the counter guarantees FIFO space for every in-flight entry.
- Load port: independent of the request/response channels and never blocked. Flush does not affect it.

## Timing
- Reset values:
  - resp_valid = 0, resp_inst = 0, resp_addr = 0, resp_fault = 0; outstanding = 0.
  - req_ready = 1 in the first cycle after reset.
  - Store contents are not reset.
- Reset mid-operation: all in-flight and buffered fetches are dropped with no response. Reset overrides flush and all handshakes.
- Latency: a fetch accepted at the edge ending cycle T gives resp_valid = 1 in cycle T+LATENCY, if all older responses have drained.
- Throughput: one fetch per cycle sustained while resp_ready = 1, provided FIFO_DEPTH >= LATENCY+1.
  - With a smaller FIFO_DEPTH, req_ready drops once outstanding reaches FIFO_DEPTH.
- Full: with outstanding == FIFO_DEPTH and a response handshake in the same cycle, req_ready stays 0. It rises the next cycle, so there is no same-cycle pass-through.
- Empty: resp_valid = 0 whenever the FIFO is empty. There is no combinational bypass from request to response.

## Test plan
- Load 0x00500093 at word 0 and 0x00A00113 at word 1. Request 0x0 then 0x4 back-to-back with resp_ready = 1 and LATENCY = 2.
  - Responses in cycles T+2 and T+3: (0x00500093, addr 0x0, fault 0), then (0x00A00113, addr 0x4, fault 0).
- Request 0x6, then 0x1000 (DEPTH_WORDS = 1024).
  - Both return resp_inst = 0x00000013, fault = 1, addr echoed.
- Hold resp_ready = 0 and issue 6 requests.
  - Exactly 4 accepted; req_ready = 0 afterwards.
  - First response held stable.
  - Release resp_ready: 4 in-order responses follow, and req_ready returns the cycle after the first handshake.
- Issue 3 requests, then assert flush with req_addr = 0x40 in the same cycle.
  - No responses for the first 3.
  - Exactly one response, for 0x40, two cycles later.
- Same-cycle load_we of 0xDEADBEEF and fetch to that word: the old word is returned. A later fetch returns 0xDEADBEEF.
- Assert rst with 2 fetches in flight.
  - No responses afterwards; resp_valid = 0 and req_ready = 1 in the first post-reset cycle.
